// File: rtl/pwm_hbridge_driver.sv
// Multi-channel H-bridge PWM driver. Duty and mode are double-buffered to period
// boundaries, and direction changes are separated by whole periods of dead time.
module pwm_hbridge_driver #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned DEAD_PERIODS = 1,
    parameter int unsigned DIV_HALF     = 8
) (
    input  logic                    clk_3125KHz,
    input  logic                    reset,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH*2-1:0]     mode,
    input  logic                    load,
    output logic [NUM_CH-1:0]       pwm_fwd,
    output logic [NUM_CH-1:0]       pwm_rev,
    output logic                    period_start,
    output logic                    clk_div
);
    localparam int unsigned DUTY_W = NUM_CH * CNT_W;
    localparam int unsigned MODE_W = NUM_CH * 2;
    localparam int unsigned DIV_W  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int unsigned DEAD_W = 4;

    localparam logic [2:0] ST_COAST = 3'd0;
    localparam logic [2:0] ST_FWD   = 3'd1;
    localparam logic [2:0] ST_REV   = 3'd2;
    localparam logic [2:0] ST_BRAKE = 3'd3;
    localparam logic [2:0] ST_DEAD  = 3'd4;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              clk_div_q, clk_div_d;
    logic [DUTY_W-1:0] sh_duty_q, sh_duty_d, act_duty_q, act_duty_d;
    logic [MODE_W-1:0] sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [2:0]        state_q [NUM_CH];
    logic [2:0]        state_d [NUM_CH];
    logic [DEAD_W-1:0] dead_q  [NUM_CH];
    logic [DEAD_W-1:0] dead_d  [NUM_CH];
    logic [2:0]        req_c   [NUM_CH];
    logic [NUM_CH-1:0] raw_c;
    logic [NUM_CH-1:0] fwd_q, fwd_d, rev_q, rev_d;
    logic              ps_q, ps_d;
    logic              wrap_c;

    assign wrap_c = (cnt_q == '1);

    // Counter, clock divider and the shadow/active register pair
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        div_d      = div_q + DIV_W'(1);
        clk_div_d  = clk_div_q;
        sh_duty_d  = sh_duty_q;
        sh_mode_d  = sh_mode_q;
        act_duty_d = act_duty_q;
        act_mode_d = act_mode_q;
        if (div_q == DIV_W'(DIV_HALF - 1)) begin
            div_d     = '0;
            clk_div_d = ~clk_div_q;
        end
        if (load) begin
            sh_duty_d = duty;
            sh_mode_d = mode;
        end
        // A load on the wrap cycle bypasses the shadow so it lands one period sooner
        if (wrap_c) begin
            act_duty_d = load ? duty : sh_duty_q;
            act_mode_d = load ? mode : sh_mode_q;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            req_c[i] = {1'b0, act_mode_d[2*i +: 2]};
            raw_c[i] = (act_duty_q[i*CNT_W +: CNT_W] == '1) ||
                       (cnt_q < act_duty_q[i*CNT_W +: CNT_W]);
        end
    end

    // Channel FSM next state, evaluated only at the wrap edge
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            state_d[i] = state_q[i];
            dead_d[i]  = dead_q[i];
            if (wrap_c) begin
                if (req_c[i] == ST_COAST) begin
                    state_d[i] = ST_COAST;
                    dead_d[i]  = '0;
                end else begin
                    case (state_q[i])
                        ST_COAST: state_d[i] = req_c[i];
                        ST_DEAD: begin
                            if (dead_q[i] <= DEAD_W'(1)) begin
                                state_d[i] = req_c[i];
                                dead_d[i]  = '0;
                            end else begin
                                dead_d[i] = dead_q[i] - DEAD_W'(1);
                            end
                        end
                        default: begin
                            if (state_q[i] != req_c[i]) begin
                                state_d[i] = ST_DEAD;
                                dead_d[i]  = DEAD_W'(DEAD_PERIODS);
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Bridge outputs from current state; only BRAKE drives both sides high
    always_comb begin
        fwd_d = '0;
        rev_d = '0;
        ps_d  = (cnt_q == '0);
        for (int i = 0; i < int'(NUM_CH); i++) begin
            case (state_q[i])
                ST_FWD:   fwd_d[i] = raw_c[i];
                ST_REV:   rev_d[i] = raw_c[i];
                ST_BRAKE: begin
                    fwd_d[i] = 1'b1;
                    rev_d[i] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= ST_COAST;
                dead_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
        end
    end

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= '0;
            clk_div_q  <= 1'b0;
            sh_duty_q  <= '0;
            sh_mode_q  <= '0;
            act_duty_q <= '0;
            act_mode_q <= '0;
            fwd_q      <= '0;
            rev_q      <= '0;
            ps_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            clk_div_q  <= clk_div_d;
            sh_duty_q  <= sh_duty_d;
            sh_mode_q  <= sh_mode_d;
            act_duty_q <= act_duty_d;
            act_mode_q <= act_mode_d;
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            ps_q       <= ps_d;
        end
    end

    assign pwm_fwd      = fwd_q;
    assign pwm_rev      = rev_q;
    assign period_start = ps_q;
    assign clk_div      = clk_div_q;

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// Directed bench for pwm_hbridge_driver: expected outputs come from a small
// per-position model of the period, channel state and divider phase.
module tb_pwm_hbridge_driver;
    localparam int C = 0;
    localparam int F = 1;
    localparam int R = 2;
    localparam int B = 3;
    localparam int D = 4;

    logic       clk_3125KHz = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] duty = '0;
    logic [3:0] mode = '0;
    logic       load = 1'b0;
    logic [1:0] pwm_fwd, pwm_rev;
    logic       period_start, clk_div;

    int checks = 0;
    int errors = 0;
    int c = 0;
    int tsr = 0;

    pwm_hbridge_driver dut (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .duty        (duty),
        .mode        (mode),
        .load        (load),
        .pwm_fwd     (pwm_fwd),
        .pwm_rev     (pwm_rev),
        .period_start(period_start),
        .clk_div     (clk_div)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    // load is a one-cycle strobe; c tracks the counter value, tsr cycles since reset
    task automatic tick();
        @(posedge clk_3125KHz);
        #1;
        load = 1'b0;
        if (reset) begin
            c   = 0;
            tsr = 0;
        end else begin
            c   = (c + 1) % 16;
            tsr = tsr + 1;
        end
    endtask

    function automatic logic raw(input int d, input int p);
        return (d == 15) || (p < d);
    endfunction

    function automatic logic [1:0] ch_exp(input int st, input int d, input int p);
        case (st)
            F:       return {raw(d, p), 1'b0};
            R:       return {1'b0, raw(d, p)};
            B:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input logic [1:0] ef, input logic [1:0] er,
                                 input logic eps, input logic ediv);
        checks += 4;
        assert (pwm_fwd === ef) else begin
            errors++;
            $error("FAIL %s pwm_fwd: observed %b expected %b", tag, pwm_fwd, ef);
        end
        assert (pwm_rev === er) else begin
            errors++;
            $error("FAIL %s pwm_rev: observed %b expected %b", tag, pwm_rev, er);
        end
        assert (period_start === eps) else begin
            errors++;
            $error("FAIL %s period_start: observed %b expected %b", tag, period_start, eps);
        end
        assert (clk_div === ediv) else begin
            errors++;
            $error("FAIL %s clk_div: observed %b expected %b", tag, clk_div, ediv);
        end
    endtask

    // n cycles within one output period; s/d give each channel's state and duty
    task automatic check_span(input string tag, input int n, input int s0, input int d0,
                              input int s1, input int d1);
        logic [1:0] e0, e1;
        int p;
        for (int k = 0; k < n; k++) begin
            tick();
            p  = (c + 15) % 16;
            e0 = ch_exp(s0, d0, p);
            e1 = ch_exp(s1, d1, p);
            check_outputs(tag, {e1[1], e0[1]}, {e1[0], e0[0]}, p == 0, ((tsr / 8) % 2) == 1);
        end
    endtask

    initial begin
        tick();
        tick();
        check_outputs("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;

        duty = 8'h05; mode = 4'b0001; load = 1'b1;
        check_span("coast_then_load", 16, C, 0, C, 0);
        check_span("ch0_fwd5", 16, F, 5, C, 0);

        duty = 8'hF5; mode = 4'b0101; load = 1'b1;
        check_span("ch1_pending", 16, F, 5, C, 0);
        check_span("ch1_duty15", 16, F, 5, F, 15);
        duty = 8'h05; load = 1'b1;
        check_span("ch1_duty0_pending", 16, F, 5, F, 15);
        check_span("ch1_duty0", 16, F, 5, F, 0);

        check_span("to_wrap", 15, F, 5, F, 0);
        duty = 8'h09; load = 1'b1;
        check_span("wrap_load", 1, F, 5, F, 0);
        check_span("bypass_duty9", 16, F, 9, F, 0);

        check_span("mid_a", 7, F, 9, F, 0);
        duty = 8'h03; load = 1'b1;
        check_span("mid_b", 9, F, 9, F, 0);
        check_span("mid_duty3", 16, F, 3, F, 0);

        duty = 8'h05; mode = 4'b0110; load = 1'b1;
        check_span("rev_pending", 16, F, 3, F, 0);
        check_span("rev_dead", 16, D, 0, F, 0);
        check_span("rev_duty5", 16, R, 5, F, 0);

        mode = 4'b1110; load = 1'b1;
        check_span("brake_pending", 16, R, 5, F, 0);
        check_span("brake_dead", 16, R, 5, D, 0);
        mode = 4'b0010; load = 1'b1;
        check_span("brake", 16, R, 5, B, 0);
        check_span("coast_after_brake", 16, R, 5, C, 0);

        duty = 8'hF5; mode = 4'b0110; load = 1'b1;
        check_span("fwd15_pending", 16, R, 5, C, 0);
        check_span("ch1_fwd15", 16, R, 5, F, 15);
        mode = 4'b1110; load = 1'b1;
        check_span("brake2_pending", 16, R, 5, F, 15);
        mode = 4'b1010; load = 1'b1;
        check_span("retarget_dead", 16, R, 5, D, 0);
        check_span("retarget_rev15", 16, R, 5, R, 15);

        mode = 4'b1001; load = 1'b1;
        check_span("fwd_pending", 16, R, 5, R, 15);
        check_span("dead_a", 6, D, 0, R, 15);
        reset = 1'b1;
        tick();
        check_outputs("reset_mid_dead", 2'b00, 2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        check_span("post_reset_a", 16, C, 0, C, 0);
        check_span("post_reset_b", 16, C, 0, C, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
